alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU interface. Accepts operation requests over a valid/ready handshake and
//  drives ALU_control/op_1/op_2 from registers. Captures ALU_result/ALU_status after a fixed settle
//  time and returns them over a valid/ready response channel with a tag and an exception flag.
//  Sits between the decode/execute control and the combinational ALU.
// PARAMETERS
//  SETTLE_CYCLES  1      cycles operands are held before capture (legal 1..15)
//  TAG_W          4      width of request/response tag
//  EXC_MASK       8'h24  status bits raising rsp_exc (bit5 signed ovf, bit2 div-by-zero)
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  req_valid      in   1      request present
//  req_ready      out  1      request accepted when valid&ready at clk edge
//  req_ctrl       in   4      ALU operation code (0010 add, 0110 sub, 0101 div, ...)
//  req_a          in   32     operand 1
//  req_b          in   32     operand 2
//  req_tag        in   TAG_W  opaque tag returned with response
//  alu_control    out  4      to ALU_control
//  alu_op_1       out  32     to ALU_op_1
//  alu_op_2       out  32     to ALU_op_2
//  alu_result     in   32     from ALU_result
//  alu_status     in   8      from ALU_status [7]zero [6]>32b [5]ovf [4]neg [3]misalign [2]div0
//  rsp_valid      out  1      response present
//  rsp_ready      in   1      response consumed when valid&ready at clk edge
//  rsp_result     out  32     captured result
//  rsp_status     out  8      captured status
//  rsp_tag        out  TAG_W  tag of the request
//  rsp_exc        out  1      |(rsp_status & EXC_MASK)
//  sticky_status  out  8      OR of all captured status (ALU_STICKY_EN only)
//  sticky_clr     in   1      clear sticky_status (ALU_STICKY_EN only)
// BEHAVIOUR
//  - Reset (async): state IDLE; req_ready=1 after reset deasserts; every other output 0; in-flight op dropped.
//  - FSM IDLE: req_ready=1; on accept latch ctrl/a/b/tag into drive regs, cnt<=SETTLE_CYCLES-1, go EVAL.
//  - EVAL: req_ready=0; alu_* held from drive regs; cnt decrements each edge.
//    At the edge with cnt==0, capture alu_result/alu_status/tag into rsp regs and go RESP.
//  - RESP: rsp_valid=1; rsp_* stable until consumed; req_ready=rsp_ready.
//    On rsp_ready & req_valid: new request latched in the same edge, go EVAL (back-to-back).
//    On rsp_ready & !req_valid: go IDLE.
//  - Latency: rsp_valid rises SETTLE_CYCLES edges after the accepting edge.
//    Max throughput: 1 op per SETTLE_CYCLES+1 cycles.
//  - alu_* outputs change only on accept. They hold their last value in IDLE/RESP (no glitch into ALU).
//  - rsp_exc is registered with rsp_status and shows the captured value; it never combines live alu_status.
//  - Status and result are passed through unmodified; div-by-zero result is whatever ALU presents.
//  - Backpressure: rsp_ready low holds state RESP indefinitely; no request is accepted meanwhile.
// CONFIGURATION
//  ALU_STICKY_EN defined:
//    - sticky_status <= sticky_status | captured status on every capture edge.
//    - sticky_clr clears it to 0.
//    - If clear and capture happen on the same edge, sticky_status <= captured status.
//    - Reset value is 0.
//  ALU_STICKY_EN undefined: sticky_status tied 8'h00; sticky_clr ignored; no sticky register exists.
// TESTING
//  1 SETTLE=1, add 0010 a=5 b=7 tag=3 -> rsp_valid 1 edge later; result=12, status=00, tag=3, exc=0.
//  2 sub 0110 a=9 b=9 -> status=8'h80, exc=0; alu_op_1/op_2 hold 9/9 through RESP and IDLE.
//  3 div 0101 a=10 b=0 -> status bit2 set, rsp_exc=1; sticky_status=8'h04 if ALU_STICKY_EN.
//  4 rsp_ready low 5 cycles -> rsp_* stable, req_ready=0; then ready+new req -> accepted same edge, no bubble.
//  5 reset asserted mid-EVAL (SETTLE=3) -> rsp_valid=0, all outputs 0 immediately; next request completes normally.
//  6 ALU_STICKY_EN: ops with status 80 then 20 -> sticky=A0; sticky_clr with capture of 10 -> sticky=10.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between execute control and alu_issue_ctrl.
// master = requester side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_ctrl;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [7:0]       rsp_status;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_exc;

    modport master (
        output req_valid, req_ctrl, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_status, rsp_tag, rsp_exc
    );

    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_status, rsp_tag, rsp_exc
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Registered initiator for the combinational ALU: hold operands, capture after settle.
// Optional sticky status accumulator enabled by defining ALU_STICKY_EN.
module alu_issue_ctrl #(
    parameter int           SETTLE_CYCLES = 1,
    parameter int           TAG_W         = 4,
    parameter logic [7:0]   EXC_MASK      = 8'h24
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_ctrl_if.slave bus,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_op_1,
    output logic [31:0] alu_op_2,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status,
    output logic [7:0]  sticky_status,
    input  logic        sticky_clr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [TAG_W-1:0] dtag_q, dtag_d;
    logic [31:0]      res_q, res_d;
    logic [7:0]       stat_q, stat_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic             exc_q, exc_d;
    logic             rdy;
    logic             accept;
    logic             capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        dtag_d  = dtag_q;
        res_d   = res_q;
        stat_d  = stat_q;
        rtag_d  = rtag_q;
        exc_d   = exc_q;
        rdy     = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            IDLE: rdy = 1'b1;
            EVAL: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rdy = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        accept = rdy & bus.req_valid;

        // Accept overrides the RESP exit so back-to-back ops skip IDLE.
        if (accept) begin
            ctrl_d  = bus.req_ctrl;
            op1_d   = bus.req_a;
            op2_d   = bus.req_b;
            dtag_d  = bus.req_tag;
            cnt_d   = CNT_INIT;
            state_d = EVAL;
        end

        if (capture) begin
            res_d  = alu_result;
            stat_d = alu_status;
            rtag_d = dtag_q;
            exc_d  = |(alu_status & EXC_MASK);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            dtag_q  <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            rtag_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            dtag_q  <= dtag_d;
            res_q   <= res_d;
            stat_q  <= stat_d;
            rtag_q  <= rtag_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.req_ready  = rdy & ~reset;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_status = stat_q;
    assign bus.rsp_tag    = rtag_q;
    assign bus.rsp_exc    = exc_q;
    assign alu_control    = ctrl_q;
    assign alu_op_1       = op1_q;
    assign alu_op_2       = op2_q;

`ifdef ALU_STICKY_EN
    logic [7:0] sticky_q, sticky_d;

    // A clear coinciding with a capture keeps only the new status.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = capture ? alu_status : 8'h00;
        end else if (capture) begin
            sticky_d = sticky_q | alu_status;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 8'h00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_status = sticky_q;
`else
    logic sticky_clr_unused;
    assign sticky_clr_unused = sticky_clr;
    assign sticky_status     = 8'h00;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl against a transaction-level model.
// A behavioural ALU sits on the alu_* side; the model predicts from the request stream.
module tb_alu_issue_ctrl;
    localparam int         SETTLE = 3;
    localparam int         TW     = 4;
    localparam logic [7:0] EXC    = 8'h24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  alu_control;
    logic [31:0] alu_op_1;
    logic [31:0] alu_op_2;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;
    logic [7:0]  sticky_status;
    logic        sticky_clr;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.TAG_W(TW)) bus ();

    alu_issue_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .TAG_W(TW),
        .EXC_MASK(EXC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .alu_control(alu_control),
        .alu_op_1(alu_op_1),
        .alu_op_2(alu_op_2),
        .alu_result(alu_result),
        .alu_status(alu_status),
        .sticky_status(sticky_status),
        .sticky_clr(sticky_clr)
    );

    function automatic logic [39:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  s;
        r = '0;
        s = '0;
        case (c)
            4'b0010: begin
                r = a + b;
                s[5] = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                r = a - b;
                s[5] = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0101: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    s[2] = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            default: r = a ^ b;
        endcase
        s[7] = (r == 32'd0);
        s[4] = r[31] & ~s[2];
        return {s, r};
    endfunction

    always_comb {alu_status, alu_result} = alu_fn(alu_control, alu_op_1, alu_op_2);

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          pend = 0;
    int          due = 0;
    logic [31:0] e_res = '0;
    logic [7:0]  e_st = '0;
    logic [TW-1:0] e_tag = '0;
    logic [3:0]  m_ctrl = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [7:0]  m_sticky = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sticky_exp();
`ifdef ALU_STICKY_EN
        return m_sticky;
`else
        return 8'h00;
`endif
    endfunction

    task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] t,
                        input logic rr, input logic clr);
        bit vis, rdy, cap;
        bus.req_valid = v;
        bus.req_ctrl  = c;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = t;
        bus.rsp_ready = rr;
        sticky_clr    = clr;
        #1;
        vis = pend && (cyc >= due);
        rdy = !pend || (vis && rr);
        check("req_ready", bus.req_ready, rdy);
        check("rsp_valid", bus.rsp_valid, vis);
        check("alu_control", alu_control, m_ctrl);
        check("alu_op_1", alu_op_1, m_a);
        check("alu_op_2", alu_op_2, m_b);
        if (vis) begin
            check("rsp_result", bus.rsp_result, e_res);
            check("rsp_status", bus.rsp_status, e_st);
            check("rsp_tag", bus.rsp_tag, e_tag);
            check("rsp_exc", bus.rsp_exc, |(e_st & EXC));
        end
        check("sticky", sticky_status, sticky_exp());
        cap = pend && (cyc + 1 == due);
        @(posedge clk);
        cyc++;
        if (clr) m_sticky = cap ? e_st : 8'h00;
        else if (cap) m_sticky = m_sticky | e_st;
        if (vis && rr) pend = 0;
        if (v && rdy) begin
            pend = 1;
            due = cyc + SETTLE;
            {e_st, e_res} = alu_fn(c, a, b);
            e_tag = t;
            m_ctrl = c;
            m_a = a;
            m_b = b;
        end
        #1;
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t);
        step(1'b1, c, a, b, t, 1'b1, 1'b0);
        repeat (SETTLE) step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_alu_control", alu_control, 4'h0);
        check("rst_alu_op_1", alu_op_1, 32'h0);
        check("rst_alu_op_2", alu_op_2, 32'h0);
        check("rst_rsp_result", bus.rsp_result, 32'h0);
        check("rst_rsp_status", bus.rsp_status, 8'h0);
        check("rst_rsp_tag", bus.rsp_tag, '0);
        check("rst_rsp_exc", bus.rsp_exc, 1'b0);
        check("rst_sticky", sticky_status, 8'h0);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        sticky_clr    = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        pend = 0;
        m_ctrl = '0;
        m_a = '0;
        m_b = '0;
        m_sticky = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [3:0] ops [6] = '{4'b0010, 4'b0110, 4'b0101, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        bus.req_valid = 1'b0;
        bus.req_ctrl  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        sticky_clr    = 1'b0;
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // add, sub hold, div-by-zero
        op(4'b0010, 32'd5, 32'd7, 4'd3);
        op(4'b0110, 32'd9, 32'd9, 4'd5);
        repeat (2) step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        op(4'b0101, 32'd10, 32'd0, 4'd7);

        // backpressure then back-to-back accept
        step(1'b1, 4'b0010, 32'd1, 32'd2, 4'd1, 1'b0, 1'b0);
        repeat (SETTLE + 5) step(1'b1, 4'b0110, 32'd3, 32'd3, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 32'd100, 32'd1, 4'd2, 1'b1, 1'b0);
        repeat (SETTLE) step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // reset mid-EVAL, then a normal op
        step(1'b1, 4'b0010, 32'd40, 32'd2, 4'd6, 1'b1, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        do_reset();
        op(4'b0010, 32'd20, 32'd22, 4'd9);

        // sticky accumulate, then clear coinciding with a capture
        step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b1);
        op(4'b0110, 32'd9, 32'd9, 4'd1);
        op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2);
        step(1'b1, 4'b0010, 32'h0, 32'h8000_0000, 4'd3, 1'b1, 1'b0);
        repeat (SETTLE - 1) step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h0000_000F;
            if ($urandom_range(0, 3) == 0) b = a;
            step($urandom_range(0, 9) < 7, ops[$urandom_range(0, 5)], a, b,
                 TW'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            if (i == 700) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
